// File: rtl/sobel_window_3x3_pkg.sv
// Shared definitions for the 3x3 Sobel window builder: pixel type,
// default image geometry and the frame-tracking state encoding.
package sobel_window_3x3_pkg;
   localparam int PIX_W      = 8;
   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;

   typedef logic [PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } state_t;
endpackage

// File: rtl/sobel_window_3x3_if.sv
// Column-in / window-out bundle between the line buffer and the Sobel window.
interface sobel_window_3x3_if
   import sobel_window_3x3_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
);
   logic                      en;
   pix_t                      data0;
   pix_t                      data1;
   pix_t                      data2;
   pix_t                      p00, p01, p02;
   pix_t                      p10, p11, p12;
   pix_t                      p20, p21, p22;
   logic                      valid;
   logic [$clog2(WIDTH)-1:0]  col;
   logic [$clog2(HEIGHT)-1:0] row;
   logic                      done;

   modport master (
      output en, data0, data1, data2,
      input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
      input  valid, col, row, done
   );

   modport slave (
      input  en, data0, data1, data2,
      output p00, p01, p02, p10, p11, p12, p20, p21, p22,
      output valid, col, row, done
   );
endinterface

// File: rtl/sobel_window_3x3_row_shift.sv
// Three-stage pixel shift register forming one row of the window;
// q0 holds the oldest (left) pixel, q2 the newest (right).
module window_row_shift3
   import sobel_window_3x3_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  pix_t din,
   output pix_t q0,
   output pix_t q1,
   output pix_t q2
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q0 <= '0;
         q1 <= '0;
         q2 <= '0;
      end else if (en) begin
         q0 <= q1;
         q1 <= q2;
         q2 <= din;
      end
   end
endmodule

// File: rtl/sobel_window_3x3.sv
// 3x3 Sobel neighbourhood builder: shifts one vertical column per enabled
// cycle and tags windows that lie fully inside the image.
module sobel_window_3x3
   import sobel_window_3x3_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
)
(
   input logic              clk,
   input logic              rst,
   sobel_window_3x3_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 3);

   state_t          state, state_nxt;
   logic [CW-1:0]   c;
   logic [RW-1:0]   r;
   logic            accept;
   logic            last_col;
   logic            valid_q;
   logic            done_q;
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   pix_t            t0, t1, t2, m0, m1, m2, b0, b1, b2;

   // Columns arriving in the DONE cycle are dropped entirely.
   assign accept   = bus.en && (state != DONE);
   assign last_col = accept && (c == C_LAST) && (r == R_LAST);

   window_row_shift3 u_top (
      .clk (clk), .rst (rst), .en (accept), .din (bus.data2),
      .q0  (t0),  .q1  (t1),  .q2 (t2)
   );

   window_row_shift3 u_mid (
      .clk (clk), .rst (rst), .en (accept), .din (bus.data1),
      .q0  (m0),  .q1  (m1),  .q2 (m2)
   );

   window_row_shift3 u_bot (
      .clk (clk), .rst (rst), .en (accept), .din (bus.data0),
      .q0  (b0),  .q1  (b1),  .q2 (b2)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (last_col)    state_nxt = DONE;
            else if (accept) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (last_col) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c       <= '0;
         r       <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         valid_q <= accept && (c >= CW'(2));
         done_q  <= last_col;
         if (accept) begin
            if (c == C_LAST) begin
               c <= '0;
               r <= (r == R_LAST) ? '0 : r + RW'(1);
            end else begin
               c <= c + CW'(1);
            end
            // Coordinates name the window centre, one column/row behind the newest pixel.
            if (c >= CW'(2)) begin
               col_q <= c - CW'(1);
               row_q <= r + RW'(1);
            end
         end
      end
   end

   assign bus.p00   = t0;
   assign bus.p01   = t1;
   assign bus.p02   = t2;
   assign bus.p10   = m0;
   assign bus.p11   = m1;
   assign bus.p12   = m2;
   assign bus.p20   = b0;
   assign bus.p21   = b1;
   assign bus.p22   = b2;
   assign bus.valid = valid_q;
   assign bus.done  = done_q;
   assign bus.col   = col_q;
   assign bus.row   = row_q;
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Directed, table-driven bench for sobel_window_3x3 on a 5x4 image.
module tb_sobel_window_3x3;
   localparam int W = 5;
   localparam int H = 4;

   typedef struct {
      logic       en;
      logic [7:0] tag;
      logic       v;
      logic       d;
      logic       chk;
      logic [2:0] col;
      logic [1:0] row;
      logic [7:0] wl, wm, wr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tab[$];

   always #5 clk = ~clk;

   sobel_window_3x3_if #(.WIDTH(W), .HEIGHT(H)) bus ();

   sobel_window_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic vec_t mk(logic en, logic [7:0] tag, logic v, logic d, logic chk,
                               logic [2:0] col, logic [1:0] row,
                               logic [7:0] wl, logic [7:0] wm, logic [7:0] wr);
      vec_t x;
      x.en = en; x.tag = tag; x.v = v; x.d = d; x.chk = chk;
      x.col = col; x.row = row; x.wl = wl; x.wm = wm; x.wr = wr;
      return x;
   endfunction

   // Column with tag k carries bottom=k, middle=k+10, top=k+20.
   function automatic logic [71:0] win_exp(logic [7:0] l, logic [7:0] m, logic [7:0] r);
      return {l + 8'd20, m + 8'd20, r + 8'd20,
              l + 8'd10, m + 8'd10, r + 8'd10,
              l, m, r};
   endfunction

   function automatic logic [71:0] win_act();
      return {bus.p00, bus.p01, bus.p02, bus.p10, bus.p11, bus.p12,
              bus.p20, bus.p21, bus.p22};
   endfunction

   task automatic check(string name, logic [71:0] act, logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic en, logic [7:0] tag);
      @(negedge clk);
      rst       = r;
      bus.en    = en;
      bus.data0 = tag;
      bus.data1 = tag + 8'd10;
      bus.data2 = tag + 8'd20;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(string tagname);
      check({tagname, ".valid"}, 72'(bus.valid), 72'(0));
      check({tagname, ".done"},  72'(bus.done),  72'(0));
      check({tagname, ".col"},   72'(bus.col),   72'(0));
      check({tagname, ".row"},   72'(bus.row),   72'(0));
      check({tagname, ".win"},   win_act(),      72'(0));
   endtask

   initial begin
      bus.en = 1'b0; bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;

      // frame 1, row 0 with gaps
      tab.push_back(mk(1,  0, 0, 0, 0, 0, 0,  0,  0,  0));
      tab.push_back(mk(0,  0, 0, 0, 0, 0, 0,  0,  0,  0));
      tab.push_back(mk(1,  1, 0, 0, 0, 0, 0,  0,  0,  0));
      tab.push_back(mk(0,  0, 0, 0, 0, 0, 0,  0,  0,  0));
      tab.push_back(mk(1,  2, 1, 0, 1, 1, 1,  0,  1,  2));
      tab.push_back(mk(1,  3, 1, 0, 1, 2, 1,  1,  2,  3));
      tab.push_back(mk(1,  4, 1, 0, 1, 3, 1,  2,  3,  4));
      tab.push_back(mk(0,  9, 0, 0, 1, 3, 1,  2,  3,  4));
      // row 1 back-to-back; window is not cleared on wrap
      tab.push_back(mk(1, 30, 0, 0, 1, 3, 1,  3,  4, 30));
      tab.push_back(mk(1, 31, 0, 0, 1, 3, 1,  4, 30, 31));
      tab.push_back(mk(1, 32, 1, 0, 1, 1, 2, 30, 31, 32));
      tab.push_back(mk(1, 33, 1, 0, 1, 2, 2, 31, 32, 33));
      tab.push_back(mk(1, 34, 1, 1, 1, 3, 2, 32, 33, 34));
      // DONE cycle: column dropped
      tab.push_back(mk(1, 99, 0, 0, 1, 3, 2, 32, 33, 34));
      // frame 2 from IDLE
      tab.push_back(mk(1, 60, 0, 0, 1, 3, 2, 33, 34, 60));
      tab.push_back(mk(1, 61, 0, 0, 1, 3, 2, 34, 60, 61));
      tab.push_back(mk(1, 62, 1, 0, 1, 1, 1, 60, 61, 62));
      tab.push_back(mk(1, 63, 1, 0, 1, 2, 1, 61, 62, 63));

      drive(1, 1, 8'($urandom));
      drive(1, 1, 8'($urandom));
      check_zero("reset");

      for (int i = 0; i < tab.size(); i++) begin
         drive(0, tab[i].en, tab[i].tag);
         check($sformatf("valid[%0d]", i), 72'(bus.valid), 72'(tab[i].v));
         check($sformatf("done[%0d]", i),  72'(bus.done),  72'(tab[i].d));
         if (tab[i].chk) begin
            check($sformatf("col[%0d]", i), 72'(bus.col), 72'(tab[i].col));
            check($sformatf("row[%0d]", i), 72'(bus.row), 72'(tab[i].row));
            check($sformatf("win[%0d]", i), win_act(), win_exp(tab[i].wl, tab[i].wm, tab[i].wr));
         end
      end

      // mid-row reset with en high: reset wins, partial frame discarded
      drive(1, 1, 8'd77);
      check_zero("midreset");
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'(70 + i));
         check($sformatf("post_valid[%0d]", i), 72'(bus.valid), 72'(i == 2));
         check($sformatf("post_done[%0d]", i),  72'(bus.done),  72'(0));
      end
      check("post_col", 72'(bus.col), 72'(1));
      check("post_row", 72'(bus.row), 72'(1));
      check("post_win", win_act(), win_exp(8'd70, 8'd71, 8'd72));

      drive(0, 0, 8'd0);
      check("idle_valid", 72'(bus.valid), 72'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sobel_window_3x3.md
# sobel_window_3x3

Builds the 3x3 pixel neighbourhood for the Sobel kernel from the three row taps of the double line buffer. Each enabled cycle, one vertical 3-pixel column (newest row plus two delayed rows) shifts into a 3x3 register window. Column/row counters and a small state machine mark which windows are fully inside the image and pulse frame completion. It sits between the line buffer and the gradient/magnitude stage.

## Interface
- `WIDTH`, 640, image width in pixels (≥3)
- `HEIGHT`, 480, image height in lines (≥3)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en_i`  in  1  column valid; driven by line-buffer `done_o`
- `data0_i`  in  8  pixel of newest row (bottom)
- `data1_i`  in  8  pixel of row − 1 (middle)
- `data2_i`  in  8  pixel of row − 2 (top)
- `p00_o`..`p22_o`  out  8 each  window, `pRC`: R 0=top..2=bottom, C 0=left(oldest)..2=right(newest)
- `valid_o`  out  1  window fully inside image
- `col_o`  out  clog2(WIDTH)  center-pixel column of current window
- `row_o`  out  clog2(HEIGHT)  center-pixel row of current window
- `done_o`  out  1  one-cycle pulse with last window of frame

## Operation
- States: IDLE, ACTIVE, DONE. IDLE→ACTIVE on first `en_i`; ACTIVE→DONE when accepting column WIDTH−1 of window-row HEIGHT−3; DONE→IDLE unconditionally next cycle.
- In IDLE and ACTIVE, `en_i`=1: shift window left (col0←col1, col1←col2), load col2 = {data2_i, data1_i, data0_i} top to bottom; increment column counter `c`.
- `en_i`=0: window, counters, coordinates hold; `valid_o`=0.
- `c` wraps WIDTH−1→0; on wrap, window-row counter `r` increments (0..HEIGHT−3). Window contents are not cleared on wrap.
- `valid_o`=1 on the cycle after accepting a column with `c`≥2; `col_o`=c−1, `row_o`=r+1 registered alongside.
- On acceptance of the last column (r=HEIGHT−3, c=WIDTH−1): `valid_o` and `done_o` both high next cycle; `c`,`r` return to 0.
- In DONE, `en_i` is ignored (column dropped, no shift); upstream must not present a new frame's first column in that cycle.
- No border padding: output covers rows 1..HEIGHT−2, cols 1..WIDTH−2, (WIDTH−2)(HEIGHT−2) windows per frame.

## Timing
- Latency 1: column accepted at edge n → window/`valid_o`/coordinates visible after edge n.
- Throughput: one column per cycle, no backpressure.
- Reset: all `p*_o`, `valid_o`, `done_o`, `col_o`, `row_o` = 0; `c`,`r` = 0; state IDLE. Reset wins over `en_i` in the same cycle; mid-frame reset discards the partial frame.
- `done_o` is high for exactly one cycle per frame, never without `valid_o`.

## Structure
- Shared package: state encoding (IDLE/ACTIVE/DONE), default WIDTH/HEIGHT, pixel width constant (8).
- One sub-module: `window_row_shift3` — 3-stage 8-bit shift register with enable, instantiated three times (top/mid/bottom). Counters, FSM and valid/done logic in the top.

## Test plan
WIDTH=5, HEIGHT=4 unless noted.
- Reset: assert `rst` 2 cycles with `en_i`=1, random data → all outputs 0, state IDLE, no `valid_o` afterward until 3 columns accepted.
- One row, back-to-back: columns c=0..4 with data0=c, data1=10+c, data2=20+c → `valid_o` after columns 2,3,4; first window top {20,21,22}, mid {10,11,12}, bottom {0,1,2}, `col_o`=1, `row_o`=1.
- Gaps: same row with `en_i` pattern 1,0,1,0,1,1,1 → identical 3 windows in order, `valid_o` 0 in every gap cycle and while holding.
- Row wrap: second row follows immediately → `valid_o` low after its columns 0,1; next window `col_o`=1, `row_o`=2.
- Frame end: two full rows → exactly 6 valid windows, `done_o` single pulse with 6th; `en_i`=1 in DONE cycle produces no shift; next frame starts cleanly from IDLE.
- Mid-row reset: reset after column 3 of row 0 → outputs 0; subsequent columns start at c=0, first `valid_o` after third new column.
